// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron array.
//   - default parameter values for the array
//   - LEAK_OFF: leak_shift encoding that disables the leak term
//   - sat_add: unsigned add clamped to an all-ones value of a given width
package lif_pkg;

  localparam int N_NEURONS_DEF = 4;
  localparam int V_WIDTH_DEF   = 8;
  localparam int I_WIDTH_DEF   = 4;
  localparam int R_WIDTH_DEF   = 3;

  localparam logic [2:0] LEAK_OFF = 3'd0;

  // Add in one extra bit, then clamp to 2^w-1. Callers cast the result down to w bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/lif_neuron_array_if.sv
// Control/data bundle of the LIF neuron array.
//   master: drives ena, step, in_current, threshold, leak_shift, refrac_cycles, mem_sel;
//           receives spike, spike_any, mem_out.
//   slave : the array side.
interface lif_neuron_array_if #(
  parameter int N_NEURONS = 4,
  parameter int V_WIDTH   = 8,
  parameter int I_WIDTH   = 4,
  parameter int R_WIDTH   = 3
);
  localparam int SEL_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  logic                           ena;
  logic                           step;
  logic [N_NEURONS*I_WIDTH-1:0]   in_current;
  logic [V_WIDTH-1:0]             threshold;
  logic [2:0]                     leak_shift;
  logic [R_WIDTH-1:0]             refrac_cycles;
  logic [SEL_W-1:0]               mem_sel;
  logic [N_NEURONS-1:0]           spike;
  logic                           spike_any;
  logic [V_WIDTH-1:0]             mem_out;

  modport master (
    output ena, step, in_current, threshold, leak_shift, refrac_cycles, mem_sel,
    input  spike, spike_any, mem_out
  );

  modport slave (
    input  ena, step, in_current, threshold, leak_shift, refrac_cycles, mem_sel,
    output spike, spike_any, mem_out
  );
endinterface

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: membrane register, refractory counter, spike flop.
//   clk, rst_n     clock, async active-low reset
//   upd            update strobe (ena && step)
//   i_cur          input current for this channel
//   threshold, leak_shift, refrac_cycles  shared config
//   v              membrane potential (register)
//   fire           combinational "spikes at the next edge", used for spike_any
//   spike          registered one-cycle spike
module lif_neuron
  import lif_pkg::*;
#(
  parameter int V_WIDTH = V_WIDTH_DEF,
  parameter int I_WIDTH = I_WIDTH_DEF,
  parameter int R_WIDTH = R_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               upd,
  input  logic [I_WIDTH-1:0] i_cur,
  input  logic [V_WIDTH-1:0] threshold,
  input  logic [2:0]         leak_shift,
  input  logic [R_WIDTH-1:0] refrac_cycles,
  output logic [V_WIDTH-1:0] v,
  output logic               fire,
  output logic               spike
);

  logic [R_WIDTH-1:0] refrac;
  logic [V_WIDTH-1:0] v_leak;
  logic [V_WIDTH-1:0] v_next;
  logic               in_refrac;

  assign in_refrac = (refrac != '0);

  always_comb begin
    v_leak = (leak_shift == LEAK_OFF) ? v : v - (v >> leak_shift);
    // Saturate rather than wrap so a large input can never look like a small potential.
    v_next = V_WIDTH'(sat_add(32'(v_leak), 32'(i_cur), V_WIDTH));
    fire   = upd && !in_refrac && (v_next >= threshold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v      <= '0;
      refrac <= '0;
      spike  <= 1'b0;
    end else begin
      spike <= fire;
      if (upd) begin
        if (in_refrac) begin
          refrac <= refrac - R_WIDTH'(1);
          v      <= '0;
        end else if (fire) begin
          v      <= '0;
          refrac <= refrac_cycles;
        end else begin
          v      <= v_next;
        end
      end
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Array of N_NEURONS independent LIF neurons sharing threshold/leak/refractory config.
//   clk, rst_n  clock, async active-low reset
//   bus         slave side of lif_neuron_array_if:
//               in : ena, step, in_current, threshold, leak_shift, refrac_cycles, mem_sel
//               out: spike (registered), spike_any (registered), mem_out (mux of registers)
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int V_WIDTH   = V_WIDTH_DEF,
  parameter int I_WIDTH   = I_WIDTH_DEF,
  parameter int R_WIDTH   = R_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  lif_neuron_array_if.slave bus
);

  logic                              upd;
  logic [N_NEURONS-1:0][V_WIDTH-1:0] v_all;
  logic [N_NEURONS-1:0]              fire_all;
  logic [N_NEURONS-1:0]              spike_all;
  logic                              spike_any_q;
  logic [V_WIDTH-1:0]                mem_out_c;

  assign upd = bus.ena && bus.step;

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_neuron
    lif_neuron #(
      .V_WIDTH (V_WIDTH),
      .I_WIDTH (I_WIDTH),
      .R_WIDTH (R_WIDTH)
    ) u_neuron (
      .clk           (clk),
      .rst_n         (rst_n),
      .upd           (upd),
      .i_cur         (bus.in_current[g*I_WIDTH +: I_WIDTH]),
      .threshold     (bus.threshold),
      .leak_shift    (bus.leak_shift),
      .refrac_cycles (bus.refrac_cycles),
      .v             (v_all[g]),
      .fire          (fire_all[g]),
      .spike         (spike_all[g])
    );
  end

  // Registered from the pre-edge fire terms so it lines up with spike exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spike_any_q <= 1'b0;
    else        spike_any_q <= |fire_all;
  end

  // Out-of-range selects read zero instead of aliasing onto a real channel.
  always_comb begin
    mem_out_c = '0;
    if (32'(bus.mem_sel) < N_NEURONS) mem_out_c = v_all[bus.mem_sel];
  end

  assign bus.spike     = spike_all;
  assign bus.spike_any = spike_any_q;
  assign bus.mem_out   = mem_out_c;

endmodule

// File: tb/tb_lif_neuron_array.sv
module tb_lif_neuron_array;
  localparam int N = 2, VW = 8, IW = 4, RW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  lif_neuron_array_if #(.N_NEURONS(N), .V_WIDTH(VW), .I_WIDTH(IW), .R_WIDTH(RW)) bus ();

  lif_neuron_array #(.N_NEURONS(N), .V_WIDTH(VW), .I_WIDTH(IW), .R_WIDTH(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cfg(input int i0, input int i1, input int th, input int ls, input int rc);
    bus.in_current    = {IW'(i1), IW'(i0)};
    bus.threshold     = VW'(th);
    bus.leak_shift    = 3'(ls);
    bus.refrac_cycles = RW'(rc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int ev2[12] = '{10, 20, 30, 40, 0, 0, 0, 10, 20, 30, 40, 0};
  int ev4[6]  = '{8, 12, 14, 15, 16, 16};

  initial begin
    // 1: reset with random inputs
    bus.ena = 1'b1; bus.step = 1'b1; bus.mem_sel = 1'b0;
    bus.in_current    = 8'($urandom);
    bus.threshold     = 8'($urandom);
    bus.leak_shift    = 3'($urandom);
    bus.refrac_cycles = 3'($urandom);
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_spike", 32'(bus.spike), 0);
    chk("rst_spike_any", 32'(bus.spike_any), 0);
    chk("rst_mem0", 32'(bus.mem_out), 0);
    bus.mem_sel = 1'b1; #1;
    chk("rst_mem1", 32'(bus.mem_out), 0);
    bus.mem_sel = 1'b0;

    // 2: integrate + refractory, period 7
    set_cfg(10, 0, 50, 0, 2);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("t2_v", 32'(bus.mem_out), 32'(ev2[k]));
      chk("t2_spike", 32'(bus.spike), (k == 4 || k == 11) ? 1 : 0);
    end

    // 3: climb to threshold 255 in 17 steps
    set_cfg(15, 0, 255, 0, 0);
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("t3_v", 32'(bus.mem_out), 32'(15 * k));
      chk("t3_spike", 32'(bus.spike), 0);
    end
    tick();
    chk("t3_spike17", 32'(bus.spike), 1);
    chk("t3_v17", 32'(bus.mem_out), 0);

    // 3b: 250 + 15 saturates to 255 and fires; wrapping would leave 9
    set_cfg(10, 0, 255, 0, 0);
    do_reset();
    repeat (25) tick();
    chk("t3b_v250", 32'(bus.mem_out), 250);
    set_cfg(15, 0, 255, 0, 0);
    tick();
    chk("t3b_sat_spike", 32'(bus.spike), 1);
    chk("t3b_sat_v", 32'(bus.mem_out), 0);

    // 4: leak equilibrium at 16, never fires
    set_cfg(8, 0, 200, 1, 0);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t4_v", 32'(bus.mem_out), 32'(ev4[k]));
    end
    for (int k = 6; k < 100; k++) begin
      tick();
      chk("t4_nospike", 32'(bus.spike), 0);
    end
    chk("t4_v_eq", 32'(bus.mem_out), 16);

    // 5: freeze, then reset during refractory
    set_cfg(10, 0, 50, 0, 2);
    do_reset();
    repeat (2) tick();
    chk("t5_v_pre", 32'(bus.mem_out), 20);
    bus.ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_frz_v", 32'(bus.mem_out), 20);
      chk("t5_frz_spike", 32'(bus.spike), 0);
    end
    bus.ena = 1'b1;
    tick(); chk("t5_v3", 32'(bus.mem_out), 30);
    tick(); chk("t5_v4", 32'(bus.mem_out), 40);
    tick(); chk("t5_spike5", 32'(bus.spike), 1);
    tick(); chk("t5_refrac_v", 32'(bus.mem_out), 0);
    rst_n = 1'b0; #1;
    chk("t5_async_v", 32'(bus.mem_out), 0);
    chk("t5_async_spike", 32'(bus.spike), 0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t5_ramp_v", 32'(bus.mem_out), 32'(10 * k));
      chk("t5_ramp_spike", 32'(bus.spike), 0);
    end
    tick();
    chk("t5_ramp_fire", 32'(bus.spike), 1);

    // 6: independence, then in-phase spikes
    set_cfg(10, 0, 50, 0, 2);
    do_reset();
    bus.mem_sel = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("t6_spike", 32'(bus.spike), (k == 4) ? 1 : 0);
      chk("t6_any", 32'(bus.spike_any), (k == 4) ? 1 : 0);
      chk("t6_mem1", 32'(bus.mem_out), 0);
    end
    set_cfg(10, 10, 50, 0, 2);
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t6_mem1_ramp", 32'(bus.mem_out), 32'(10 * k));
    end
    tick();
    chk("t6_both", 32'(bus.spike), 3);
    chk("t6_both_any", 32'(bus.spike_any), 1);
    bus.mem_sel = 1'b0;

    // threshold 0, no refractory: fires every step
    set_cfg(0, 0, 0, 0, 0);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("th0_spike", 32'(bus.spike), 3);
    end
    bus.step = 1'b0;
    tick();
    chk("nostep_spike", 32'(bus.spike), 0);
    chk("nostep_any", 32'(bus.spike_any), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
